// File: rtl/aes_ahb_master_if.sv
// AHB-Lite bus bundle between the AES master and the AES accelerator slave port.
// Single 128-bit transfers only; the master side drives address/control/write data.
interface aes_ahb_master_if;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic         HSELx;
    logic [127:0] HWDATA;
    logic [127:0] HRDATA;
    logic         HREADY;
    logic         HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HSELx, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HSELx, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/aes_ahb_master.sv
// AHB-Lite initiator running one AES "encrypt block" command: key write, data write,
// status polling, result read. Optional key cache selected by AES_MASTER_KEYCACHE_EN.
module aes_ahb_master #(
    parameter logic [31:0] BASE_ADDR  = 32'hF0F0_F0F0,
    parameter int          POLL_LIMIT = 64
) (
    input  logic          HCLK,
    input  logic          HRST,
    input  logic          start,
    input  logic [127:0]  key,
    input  logic [127:0]  ptext,
    output logic          busy,
    output logic          done,
    output logic [127:0]  result,
    output logic          err,
    output logic [1:0]    err_code,
    aes_ahb_master_if.master ahb
);

    localparam int PCW = $clog2(POLL_LIMIT + 1);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [31:0] ADDR_KEY    = BASE_ADDR;
    localparam logic [31:0] ADDR_DATA   = BASE_ADDR + 32'h10;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h20;
    localparam logic [31:0] ADDR_RESULT = BASE_ADDR + 32'h30;

    typedef enum logic [3:0] {
        IDLE,
        KEY_A,
        KEY_D,
        DAT_A,
        DAT_D,
        POLL_A,
        POLL_D,
        RES_A,
        RES_D
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d;
    logic [127:0]   ptext_q, ptext_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic [PCW-1:0] poll_inc;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [1:0]     err_code_q, err_code_d;
    logic [127:0]   result_q, result_d;
    logic [31:0]    haddr_q, haddr_d;
    logic [1:0]     htrans_q, htrans_d;
    logic           hwrite_q, hwrite_d;
    logic           hsel_q, hsel_d;
    logic [127:0]   hwdata_q, hwdata_d;
    logic           cache_hit;

`ifdef AES_MASTER_KEYCACHE_EN
    // Last key that produced a good result; a hit lets the command skip the key write.
    logic [127:0]   cache_key_q, cache_key_d;
    logic           cache_vld_q, cache_vld_d;

    assign cache_hit = cache_vld_q && (key == cache_key_q);

    always_comb begin
        cache_key_d = cache_key_q;
        cache_vld_d = cache_vld_q;
        if (err_d) begin
            cache_vld_d = 1'b0;
        end else if (done_d) begin
            cache_key_d = key_q;
            cache_vld_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRST) begin
            cache_key_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    assign poll_inc = poll_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ptext_d    = ptext_q;
        poll_cnt_d = poll_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        result_d   = result_q;

        // busy stays up through the done/err cycle and drops one cycle later
        if (done_q || err_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    key_d      = key;
                    ptext_d    = ptext;
                    busy_d     = 1'b1;
                    poll_cnt_d = '0;
                    err_code_d = 2'b00;
                    state_d    = cache_hit ? DAT_A : KEY_A;
                end
            end
            KEY_A:  state_d = KEY_D;
            DAT_A:  state_d = DAT_D;
            POLL_A: state_d = POLL_D;
            RES_A:  state_d = RES_D;
            KEY_D, DAT_D, POLL_D, RES_D: begin
                if (ahb.HREADY) begin
                    if (ahb.HRESP) begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                    end else begin
                        case (state_q)
                            KEY_D: state_d = DAT_A;
                            DAT_D: state_d = POLL_A;
                            POLL_D: begin
                                if (ahb.HRDATA[0]) begin
                                    state_d = RES_A;
                                end else begin
                                    poll_cnt_d = poll_inc;
                                    if (poll_inc == PCW'(POLL_LIMIT)) begin
                                        state_d    = IDLE;
                                        err_d      = 1'b1;
                                        err_code_d = 2'b10;
                                    end else begin
                                        state_d = POLL_A;
                                    end
                                end
                            end
                            default: begin
                                result_d = ahb.HRDATA;
                                done_d   = 1'b1;
                                state_d  = IDLE;
                            end
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with state_q.
    always_comb begin
        htrans_d = HTRANS_IDLE;
        hsel_d   = 1'b0;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;

        case (state_d)
            KEY_A: begin
                htrans_d = HTRANS_NONSEQ;
                hsel_d   = 1'b1;
                haddr_d  = ADDR_KEY;
                hwrite_d = 1'b1;
            end
            DAT_A: begin
                htrans_d = HTRANS_NONSEQ;
                hsel_d   = 1'b1;
                haddr_d  = ADDR_DATA;
                hwrite_d = 1'b1;
            end
            POLL_A: begin
                htrans_d = HTRANS_NONSEQ;
                hsel_d   = 1'b1;
                haddr_d  = ADDR_STATUS;
                hwrite_d = 1'b0;
            end
            RES_A: begin
                htrans_d = HTRANS_NONSEQ;
                hsel_d   = 1'b1;
                haddr_d  = ADDR_RESULT;
                hwrite_d = 1'b0;
            end
            KEY_D:   hwdata_d = key_q;
            DAT_D:   hwdata_d = ptext_q;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRST) begin
            state_q    <= IDLE;
            key_q      <= '0;
            ptext_q    <= '0;
            poll_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            result_q   <= '0;
            haddr_q    <= '0;
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
            hsel_q     <= 1'b0;
            hwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            ptext_q    <= ptext_d;
            poll_cnt_q <= poll_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            result_q   <= result_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hsel_q     <= hsel_d;
            hwdata_q   <= hwdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign result     = result_q;

    assign ahb.HADDR  = haddr_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HSELx  = hsel_q;
    assign ahb.HWDATA = hwdata_q;
    assign ahb.HSIZE  = 3'b100;
    assign ahb.HBURST = 3'b000;

endmodule

// File: tb/tb_aes_ahb_master.sv
// Directed bench for aes_ahb_master with a scripted single-transfer AHB slave.
// Expectations change with AES_MASTER_KEYCACHE_EN (key-cache hit skips the key write).
module tb_aes_ahb_master;

    localparam logic [31:0]  BASE = 32'hF0F0_F0F0;
    localparam logic [127:0] CT   = 128'h3925841D_02DC09FB_DC118597_196A0B32;
    localparam logic [127:0] K1   = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
    localparam logic [127:0] P1   = 128'h3243F6A8_885A308D_313198A2_E0370734;
    localparam logic [127:0] K2   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] K3   = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
    localparam logic [127:0] K4   = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;
    localparam logic [127:0] K5   = 128'h11111111_22222222_33333333_44444444;

    logic         HCLK = 1'b0;
    logic         HRST = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [127:0] ptext = '0;
    logic         busy, done, err;
    logic [127:0] result;
    logic [1:0]   err_code;

    aes_ahb_master_if bus ();

    aes_ahb_master #(.BASE_ADDR(BASE), .POLL_LIMIT(4)) dut (
        .HCLK     (HCLK),
        .HRST     (HRST),
        .start    (start),
        .key      (key),
        .ptext    (ptext),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err),
        .err_code (err_code),
        .ahb      (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-command observations filled by run_cmd
    int          r_done_cyc, r_err_cyc, r_nonseq, r_key_wr, r_polls, r_bad;
    logic [1:0]  r_code;
    logic        r_busy_pulse, r_busy_end, r_timeout;
    logic [127:0] r_result;
    logic [31:0] r_addr [0:7];

    task automatic check_reset(input string t);
        chk({t, "_htrans"}, 128'(bus.HTRANS), 128'd0);
        chk({t, "_haddr"},  128'(bus.HADDR),  128'd0);
        chk({t, "_hwrite"}, 128'(bus.HWRITE), 128'd0);
        chk({t, "_hsel"},   128'(bus.HSELx),  128'd0);
        chk({t, "_hwdata"}, bus.HWDATA,       128'd0);
        chk({t, "_hsize"},  128'(bus.HSIZE),  128'd4);
        chk({t, "_hburst"}, 128'(bus.HBURST), 128'd0);
        chk({t, "_busy"},   128'(busy),       128'd0);
        chk({t, "_done"},   128'(done),       128'd0);
        chk({t, "_err"},    128'(err),        128'd0);
        chk({t, "_code"},   128'(err_code),   128'd0);
        chk({t, "_result"}, result,           128'd0);
    endtask

    // Issues one command and plays the slave cycle by cycle. zeros<0 means the
    // status never reports done. Ends at the cycle after done/err (busy low).
    task automatic run_cmd(input logic [127:0] k, input logic [127:0] p, input int zeros,
                           input int dwaits, input bit kerr, input int abort_at);
        int cyc, wait_left, err_left, poll_idx, pulses;
        bit in_d, d_first, fin, completed;
        logic [31:0] d_addr;
        r_done_cyc = 0; r_err_cyc = 0; r_nonseq = 0; r_key_wr = 0; r_polls = 0; r_bad = 0;
        r_code = 2'b00; r_busy_pulse = 1'b0; r_busy_end = 1'b1; r_timeout = 1'b0; r_result = '0;
        for (int i = 0; i < 8; i++) r_addr[i] = '0;
        in_d = 0; d_first = 0; fin = 0; completed = 0; poll_idx = 0;
        wait_left = 0; err_left = 0; d_addr = '0;
        start = 1'b1; key = k; ptext = p;
        @(posedge HCLK); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc <= 200) begin
            if (fin) begin
                r_busy_end = busy;
                completed = 1;
                break;
            end
            if (done && err) r_bad++;
            if (done && r_done_cyc == 0) begin
                r_done_cyc = cyc; r_busy_pulse = busy; r_code = err_code; r_result = result; fin = 1;
            end
            if (err && r_err_cyc == 0) begin
                r_err_cyc = cyc; r_busy_pulse = busy; r_code = err_code; fin = 1;
            end
            bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
            if (bus.HTRANS == 2'b10) begin
                if (!bus.HSELx) r_bad++;
                if (bus.HWRITE != (bus.HADDR < BASE + 32'h20)) r_bad++;
                if (r_nonseq < 8) r_addr[r_nonseq] = bus.HADDR;
                r_nonseq++;
                if (bus.HADDR == BASE) r_key_wr++;
                if (bus.HADDR == BASE + 32'h20) r_polls++;
                d_addr = bus.HADDR; in_d = 1; d_first = 1;
            end else begin
                if (bus.HTRANS != 2'b00 || bus.HSELx) r_bad++;
                if (in_d) begin
                    if (d_first) begin
                        wait_left = (d_addr == BASE + 32'h10) ? dwaits : 0;
                        err_left  = (d_addr == BASE && kerr) ? 2 : 0;
                        d_first = 0;
                    end
                    if (d_addr == BASE && bus.HWDATA != k) r_bad++;
                    if (d_addr == BASE + 32'h10 && bus.HWDATA != p) r_bad++;
                    if (err_left == 2) begin
                        bus.HREADY = 1'b0; bus.HRESP = 1'b1; err_left = 1;
                    end else if (err_left == 1) begin
                        bus.HRESP = 1'b1; err_left = 0; in_d = 0;
                    end else if (wait_left > 0) begin
                        bus.HREADY = 1'b0; wait_left--;
                    end else begin
                        if (d_addr == BASE + 32'h20) begin
                            bus.HRDATA = (zeros >= 0 && poll_idx >= zeros) ? 128'd1 : 128'd0;
                            poll_idx++;
                        end else if (d_addr == BASE + 32'h30) begin
                            bus.HRDATA = CT;
                        end
                        in_d = 0;
                    end
                end
            end
            if (abort_at == cyc) begin
                HRST = 1'b1;
                @(posedge HCLK); #1;
                HRST = 1'b0;
                bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
                check_reset("abort");
                pulses = 0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge HCLK); #1;
                    pulses += int'(done) + int'(err);
                end
                chk("abort_no_pulse", 128'(pulses), 128'd0);
                completed = 1;
                break;
            end
            @(posedge HCLK); #1;
            cyc++;
        end
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        if (!completed) r_timeout = 1'b1;
    endtask

    task automatic check_run(input string t, input int exp_done, input int exp_err,
                             input logic [1:0] exp_code, input int exp_kw, input int exp_polls);
        chk({t, "_timeout"},   128'(r_timeout),    128'd0);
        chk({t, "_done_cyc"},  128'(r_done_cyc),   128'(exp_done));
        chk({t, "_err_cyc"},   128'(r_err_cyc),    128'(exp_err));
        chk({t, "_err_code"},  128'(r_code),       128'(exp_code));
        chk({t, "_key_wr"},    128'(r_key_wr),     128'(exp_kw));
        chk({t, "_polls"},     128'(r_polls),      128'(exp_polls));
        chk({t, "_protocol"},  128'(r_bad),        128'd0);
        chk({t, "_busy_pulse"}, 128'(r_busy_pulse), 128'd1);
        chk({t, "_busy_end"},  128'(r_busy_end),   128'd0);
        $display("[TB] %s: done_cyc=%0d err_cyc=%0d code=%0d key_wr=%0d polls=%0d",
                 t, r_done_cyc, r_err_cyc, r_code, r_key_wr, r_polls);
    endtask

    initial begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        check_reset("reset");
        HRST = 1'b0;
        @(posedge HCLK); #1;
        check_reset("post_reset");

        // T1: zero wait, status done on first poll
        run_cmd(K1, P1, 0, 0, 1'b0, 0);
        check_run("t1", 9, 0, 2'b00, 1, 1);
        chk("t1_result", r_result, CT);
        chk("t1_nonseq", 128'(r_nonseq), 128'd4);
        chk("t1_addr0", 128'(r_addr[0]), 128'hF0F0F0F0);
        chk("t1_addr1", 128'(r_addr[1]), 128'hF0F0F100);
        chk("t1_addr2", 128'(r_addr[2]), 128'hF0F0F110);
        chk("t1_addr3", 128'(r_addr[3]), 128'hF0F0F120);
        chk("t1_result_held", result, CT);

        // T2: three wait states in the plaintext data phase
        run_cmd(K2, P1, 0, 3, 1'b0, 0);
        check_run("t2", 12, 0, 2'b00, 1, 1);
        chk("t2_result", r_result, CT);

        // T3: status 0, 0, then 1
        run_cmd(K3, P1, 2, 0, 1'b0, 0);
        check_run("t3", 13, 0, 2'b00, 1, 3);

        // T4: status never done, POLL_LIMIT=4
        run_cmd(K4, P1, -1, 0, 1'b0, 0);
        check_run("t4", 0, 13, 2'b10, 1, 4);
        chk("t4_code_held", 128'(err_code), 128'd2);

        // T5: two-cycle ERROR response during the key write
        run_cmd(K5, P1, 0, 0, 1'b1, 0);
        check_run("t5", 0, 4, 2'b01, 1, 0);
        chk("t5_nonseq", 128'(r_nonseq), 128'd1);

        // T6: started immediately in the cycle after the error's busy drop
        run_cmd(K1, P1, 0, 0, 1'b0, 0);
        check_run("t6", 9, 0, 2'b00, 1, 1);
        chk("t6_result", r_result, CT);

        // T7: same key again
        run_cmd(K1, P1, 0, 0, 1'b0, 0);
`ifdef AES_MASTER_KEYCACHE_EN
        check_run("t7", 7, 0, 2'b00, 0, 1);
        chk("t7_addr0", 128'(r_addr[0]), 128'hF0F0F100);
`else
        check_run("t7", 9, 0, 2'b00, 1, 1);
        chk("t7_addr0", 128'(r_addr[0]), 128'hF0F0F0F0);
`endif
        chk("t7_result", r_result, CT);

        // T8: reset asserted while polling
        run_cmd(K1, P1, -1, 0, 1'b0, 6);
        chk("t8_timeout", 128'(r_timeout), 128'd0);
        chk("t8_done_cyc", 128'(r_done_cyc), 128'd0);
        $display("[TB] t8: reset during poll, polls=%0d", r_polls);

        // T9: same key after reset must be written again
        run_cmd(K1, P1, 0, 0, 1'b0, 0);
        check_run("t9", 9, 0, 2'b00, 1, 1);
        chk("t9_addr0", 128'(r_addr[0]), 128'hF0F0F0F0);
        chk("t9_result", r_result, CT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_ahb_master.md
# aes_ahb_master

AHB-Lite initiator that drives the AES accelerator's slave port. A local client issues one "encrypt block" command, and the master runs the full bus sequence on its own:
- write the 128-bit key,
- write the 128-bit plaintext,
- poll the status word until done,
- read the 128-bit ciphertext and return it.

It sits between the system-side command source and the AES slave's AHB port, and is the bus-master counterpart of that slave.

## Interface
- BASE_ADDR, 32'hF0F0_F0F0: AES slave base. Key register at +0x00, data at +0x10, status at +0x20, result at +0x30.
- POLL_LIMIT, 64: maximum status reads before a timeout error.
- HCLK  in  1  single clock; all logic on the rising edge.
- HRST  in  1  reset, synchronous and active-high.
- start  in  1  command strobe; accepted only when busy=0.
- key  in  128  key, captured on acceptance.
- ptext  in  128  plaintext, captured on acceptance.
- busy  out  1  high from the acceptance edge until the cycle after done or err.
- done  out  1  one-cycle pulse; result is valid.
- result  out  128  ciphertext; held until the next done.
- err  out  1  one-cycle pulse on abort.
- err_code  out  2  01 = bus error (HRESP), 10 = poll timeout; held until the next start.
- HADDR  out  32  transfer address.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HWRITE  out  1  1 = write.
- HSIZE  out  3  constant 3'b100 (128-bit).
- HBURST  out  3  constant 3'b000 (SINGLE).
- HSELx  out  1  high during the address phase.
- HWDATA  out  128  write data, driven during the data phase.
- HRDATA  in  128  read data.
- HREADY  in  1  transfer complete / slave ready.
- HRESP  in  1  1 = ERROR.

## Operation
- States and transitions:
  - IDLE.
  - KEY_A → KEY_D.
  - DAT_A → DAT_D.
  - POLL_A → POLL_D.
  - RES_A → RES_D.
  - After RES_D: return to IDLE and pulse done.
- Transfers are non-pipelined:
  - *_A state: one address-phase cycle with HTRANS=NONSEQ, HSELx=1 and HADDR/HWRITE set.
  - *_D state: HTRANS=IDLE and HSELx=0.
  - The master stays in *_D while HREADY=0.
- Writes: HWDATA = key in KEY_D, ptext in DAT_D. HWDATA is held stable for the whole data phase.
- POLL_D completing with HRDATA[0]=1 → RES_A.
- POLL_D completing with HRDATA[0]=0:
  - increment poll_cnt;
  - if poll_cnt reaches POLL_LIMIT → IDLE with err and err_code=10;
  - otherwise → POLL_A.
- RES_D completion: result ← HRDATA; done pulses in the next cycle.
- Bus error: any *_D cycle with HRESP=1 and HREADY=1 → IDLE, err pulse, err_code=01. A cycle with HRESP=1 and HREADY=0 (first error cycle) keeps HTRANS=IDLE.
- start with busy=1 is ignored. There is no queueing.
- poll_cnt clears on every acceptance.

## Timing
- Reset values:
  - HTRANS=00, HADDR=0, HWRITE=0, HSELx=0, HWDATA=0;
  - HSIZE=3'b100, HBURST=3'b000;
  - busy=0, done=0, err=0, err_code=00, result=0;
  - state IDLE, poll_cnt=0.
- With start sampled at edge E, KEY_A is driven in the cycle after E (c1).
- Zero wait states, status done on the first poll: c1 KEY_A, c2 KEY_D, c3 DAT_A, c4 DAT_D, c5 POLL_A, c6 POLL_D, c7 RES_A, c8 RES_D, c9 done=1, c10 busy=0.
- Each HREADY=0 cycle adds one cycle. Each extra poll adds 2 cycles.
- HRST mid-sequence: the next cycle shows reset values, and no done or err pulse is produced. An in-flight slave data phase is simply abandoned.
- done and err are never high in the same cycle.

## Configuration
- AES_MASTER_KEYCACHE_EN, defined:
  - the master stores the last key that completed successfully plus a valid bit;
  - if the accepted key matches and valid=1, KEY_A/KEY_D are skipped (start → DAT_A);
  - zero-wait latency becomes 7 cycles to done;
  - valid clears on reset and on any err.
- Not defined: the key is always written; no cache storage is built.

## Test plan
- Reset, then zero-wait run:
  - stimulus: key=2B7E1516_28AED2A6_ABF71588_09CF4F3C, ptext=3243F6A8_885A308D_313198A2_E0370734; slave returns status 1 then HRDATA=3925841D_02DC09FB_DC118597_196A0B32;
  - required: done in c9, result equals that value;
  - required: addresses F0F0F0F0, F0F0F100, F0F0F110, F0F0F120 in order, with HTRANS NONSEQ only in the *_A cycles.
- Slave holds HREADY=0 for 3 cycles in DAT_D → HWDATA stays = ptext throughout; done arrives 3 cycles later (c12).
- Status reads 0 twice, then 1 → three POLL_A cycles; done in c13.
- Status always 0 with POLL_LIMIT=4 → err=1 with err_code=10 after the 4th poll; done is never asserted.
- Two-cycle ERROR response in KEY_D → err with err_code=01; no DAT_A issued; start accepted again in the following cycle.
- With AES_MASTER_KEYCACHE_EN: repeat a command with the same key → no write to F0F0F0F0; done in c7. Then assert HRST mid-poll → all outputs return to reset values; next command writes the key again.
